// File: rtl/keypad_emulator.sv
// 4x4 keypad matrix emulator: plays timed key presses (bounce, hold, bounce, gap)
// and answers the scanner's active-low row drive on the active-low column lines.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned GAP_CYCLES    = 1000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       pressed,
  output logic       done
);

  localparam int unsigned HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int unsigned GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam logic [CNT_W-1:0] BOUNCE_LD =
    (BOUNCE_CYCLES == 0) ? '0 : CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_P,
    S_HOLD,
    S_BOUNCE_R,
    S_GAP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       cur_key;
  logic [7:0]       lfsr;
  logic             load_key;
  logic             contact;
  logic [3:0]       col_next;

  assign busy      = (state != S_IDLE);
  assign key_ready = (state == S_IDLE) && !reset;

  // Phase sequencing and switch-matrix response
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_key   = 1'b0;
    contact    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (key_valid) begin
          load_key = 1'b1;
          if (BOUNCE_CYCLES == 0) begin
            state_next = S_HOLD;
            cnt_next   = HOLD_LD;
          end else begin
            state_next = S_BOUNCE_P;
            cnt_next   = BOUNCE_LD;
          end
        end
      end
      S_BOUNCE_P: begin
        contact = lfsr[0];
        if (cnt == '0) begin
          state_next = S_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        contact = 1'b1;
        if (cnt == '0) begin
          if (BOUNCE_CYCLES == 0) begin
            state_next = S_GAP;
            cnt_next   = GAP_LD;
          end else begin
            state_next = S_BOUNCE_R;
            cnt_next   = BOUNCE_LD;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_BOUNCE_R: begin
        contact = lfsr[0];
        if (cnt == '0) begin
          state_next = S_GAP;
          cnt_next   = GAP_LD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    col_next = 4'hF;
    if (contact) col_next[cur_key[1:0]] = row[cur_key[3:2]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cur_key <= '0;
      lfsr    <= 8'hA5;
      col     <= 4'hF;
      pressed <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      if (load_key) cur_key <= key_code;
      // Fibonacci x^8+x^6+x^5+x^4+1, free-running
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      col     <= col_next;
      pressed <= (state_next == S_HOLD);
      done    <= (state == S_GAP) && (state_next == S_IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: timeline model with a column scoreboard.
module tb_keypad_emulator;

  localparam int B = 4;
  localparam int H = 8;
  localparam int G = 4;
  localparam int D = 2 * B + H + G;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row = 4'hF, key_code = 4'h0, col;
  logic       key_valid = 1'b0, key_ready, busy, pressed, done;
  logic [3:0] z_row = 4'hF, z_key = 4'h0, z_col;
  logic       z_valid = 1'b0, z_ready, z_busy, z_pressed, z_done;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  logic [3:0] z_q[$];
  logic [7:0] tb_lfsr;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(B), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(24)) u_dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .pressed(pressed), .done(done)
  );

  keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(8)) u_zero (
    .clk(clk), .reset(reset), .row(z_row), .col(z_col), .key_code(z_key),
    .key_valid(z_valid), .key_ready(z_ready), .busy(z_busy), .pressed(z_pressed), .done(z_done)
  );

  // Reference bounce source, x^8+x^6+x^5+x^4+1 seeded 8'hA5
  always @(posedge clk) begin
    if (reset) tb_lfsr <= 8'hA5;
    else       tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One press on the main instance; starts in the current cycle, returns in the done cycle
  task automatic play(input logic [3:0] key, input logic [3:0] row_a, input logic [3:0] row_b,
                      input int sw_at, input bit chain);
    logic [3:0] rv, e, got_exp;
    bit contact;
    for (int k = 0; k <= D + 1; k++) begin
      rv  = (k >= sw_at) ? row_b : row_a;
      row = rv;
      if (k == 0) begin
        key_code  = key;
        key_valid = 1'b1;
        tests++;
        if (key_ready !== 1'b1) begin
          fails++;
          $display("FAIL accept_ready key=%h: got %b expected 1", key, key_ready);
        end
      end else begin
        got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        tests++;
        if (col !== got_exp) begin
          fails++;
          $display("FAIL col key=%h k=%0d: got %b expected %b", key, k, col, got_exp);
        end
        tests++;
        if (busy !== (k <= D)) begin
          fails++;
          $display("FAIL busy key=%h k=%0d: got %b expected %b", key, k, busy, k <= D);
        end
        tests++;
        if (pressed !== (k >= B + 1 && k <= B + H)) begin
          fails++;
          $display("FAIL pressed key=%h k=%0d: got %b expected %b", key, k, pressed,
                   (k >= B + 1 && k <= B + H));
        end
        tests++;
        if (done !== (k == D + 1) || key_ready !== (k == D + 1)) begin
          fails++;
          $display("FAIL done_ready key=%h k=%0d: got %b%b expected %b%b", key, k, done,
                   key_ready, k == D + 1, k == D + 1);
        end
        if (k == 1) begin
          if (chain) key_code = ~key;
          else       key_valid = 1'b0;
        end
        if (k == D + 1 && !chain) key_valid = 1'b0;
      end
      if (k <= D) begin
        if (k == 0) contact = 1'b0;
        else if (k <= B) contact = tb_lfsr[0];
        else if (k <= B + H) contact = 1'b1;
        else if (k <= 2 * B + H) contact = tb_lfsr[0];
        else contact = 1'b0;
        e = 4'hF;
        if (contact) e[key[1:0]] = rv[key[3:2]];
        exp_q.push_back(e);
        step();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests++;
    if (key_ready !== 1'b0 || z_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_low: got %b%b expected 00", key_ready, z_ready);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (col !== 4'hF || z_col !== 4'hF) begin
      fails++;
      $display("FAIL reset_col: got %h/%h expected f/f", col, z_col);
    end
    tests++;
    if ({key_ready, busy, pressed, done} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 1000", {key_ready, busy, pressed, done});
    end
    step();
  endtask

  task automatic test_single_press();
    play(4'h6, 4'b1101, 4'b1101, 99, 1'b0);
    step();
  endtask

  task automatic test_row_mismatch();
    play(4'h6, 4'b1110, 4'b1110, 99, 1'b0);
    step();
    play(4'h6, 4'b1110, 4'b1101, B + 3, 1'b0);
    step();
  endtask

  task automatic test_zero_bounce();
    logic [3:0] e;
    int lows = 0;
    z_key   = 4'hF;
    z_row   = 4'b0111;
    z_valid = 1'b1;
    tests++;
    if (z_ready !== 1'b1) begin
      fails++;
      $display("FAIL zb_ready: got %b expected 1", z_ready);
    end
    z_q.push_back(4'hF);
    z_q.push_back(4'b0111);
    z_q.push_back(4'hF);
    z_q.push_back(4'hF);
    step();
    z_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      e = z_q.pop_front();
      if (z_col == 4'b0111) lows++;
      tests++;
      if (z_col !== e) begin
        fails++;
        $display("FAIL zb_col k=%0d: got %b expected %b", k, z_col, e);
      end
      tests++;
      if ({z_busy, z_pressed, z_done} !== {k <= 2, k == 1, k == 3}) begin
        fails++;
        $display("FAIL zb_flags k=%0d: got %b expected %b", k, {z_busy, z_pressed, z_done},
                 {k <= 2, k == 1, k == 3});
      end
      step();
    end
    tests++;
    if (lows != 1) begin
      fails++;
      $display("FAIL zb_low_cycles: got %0d expected 1", lows);
    end
  endtask

  task automatic test_back_to_back();
    play(4'h0, 4'b1110, 4'b1110, 99, 1'b1);
    play(4'h5, 4'b1101, 4'b1101, 99, 1'b0);
    step();
  endtask

  task automatic test_mid_reset();
    key_code  = 4'h6;
    row       = 4'b1101;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (B + 2) step();
    tests++;
    if (pressed !== 1'b1) begin
      fails++;
      $display("FAIL mid_in_hold: got %b expected 1", pressed);
    end
    reset = 1'b1;
    step();
    tests++;
    if ({col, pressed, busy, done, key_ready} !== {4'hF, 4'b0000}) begin
      fails++;
      $display("FAIL mid_reset_state: got %b expected 11110000",
               {col, pressed, busy, done, key_ready});
    end
    reset = 1'b0;
    #1;
    tests++;
    if (key_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_ready: got %b expected 1", key_ready);
    end
    play(4'h6, 4'b1101, 4'b1101, 99, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_row_mismatch();
    test_zero_bounce();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
